// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG master: TAP state codes, command opcodes,
// controller states and the fixed tick counts of each TMS sequence.
package jtag_pkg;

    // TAP controller state encodings (IEEE 1149.1 numbering)
    localparam logic [3:0] TAP_EX2DR = 4'h0;
    localparam logic [3:0] TAP_EX1DR = 4'h1;
    localparam logic [3:0] TAP_SHDR  = 4'h2;
    localparam logic [3:0] TAP_PAUDR = 4'h3;
    localparam logic [3:0] TAP_SELIR = 4'h4;
    localparam logic [3:0] TAP_UPDDR = 4'h5;
    localparam logic [3:0] TAP_CAPDR = 4'h6;
    localparam logic [3:0] TAP_SELDR = 4'h7;
    localparam logic [3:0] TAP_EX2IR = 4'h8;
    localparam logic [3:0] TAP_EX1IR = 4'h9;
    localparam logic [3:0] TAP_SHIR  = 4'hA;
    localparam logic [3:0] TAP_PAUIR = 4'hB;
    localparam logic [3:0] TAP_RTI   = 4'hC;
    localparam logic [3:0] TAP_UPDIR = 4'hD;
    localparam logic [3:0] TAP_CAPIR = 4'hE;
    localparam logic [3:0] TAP_TLR   = 4'hF;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_IDLE  = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } ctrl_state_t;

    // Tick counts of the fixed parts of each sequence
    localparam int INIT_TICKS   = 6;  // TMS 1,1,1,1,1,0
    localparam int RESET_TICKS  = 6;  // TMS 1,1,1,1,1,0
    localparam int IR_PRE_TICKS = 4;  // TMS 1,1,0,0
    localparam int IR_PRE_ONES  = 2;
    localparam int DR_PRE_TICKS = 3;  // TMS 1,0,0
    localparam int POST_TICKS   = 2;  // TMS 1,0

endpackage

// File: rtl/jtag_tap_mirror.sv
// Local copy of the target's TAP controller, advanced on every TCK rise so
// software can see which state the target is believed to be in.
module jtag_tap_mirror
    import jtag_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       tck_rise,
    input  logic       tms,
    output logic [3:0] tap_state
);

    function automatic logic [3:0] tap_next(input logic [3:0] cur, input logic tms_bit);
        logic [3:0] nxt;
        nxt = TAP_TLR;
        case (cur)
            TAP_TLR:   nxt = tms_bit ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   nxt = tms_bit ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: nxt = tms_bit ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: nxt = tms_bit ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  nxt = tms_bit ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: nxt = tms_bit ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: nxt = tms_bit ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: nxt = tms_bit ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: nxt = tms_bit ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: nxt = tms_bit ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: nxt = tms_bit ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  nxt = tms_bit ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: nxt = tms_bit ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: nxt = tms_bit ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: nxt = tms_bit ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: nxt = tms_bit ? TAP_SELDR : TAP_RTI;
            default:   nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

    // Advance the mirrored TAP state on each TCK rising edge
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tap_state <= TAP_TLR;
        end else if (tck_rise) begin
            tap_state <= tap_next(tap_state, tms);
        end
    end

endmodule

// File: rtl/jtag_master_seq.sv
// Bus-side JTAG master: accepts reset / IR-scan / DR-scan / idle commands,
// generates TCK/TMS/TDI from the system clock, captures TDO, and always
// parks the TAP in Run-Test/Idle between commands.
module jtag_master_seq
    import jtag_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 6,
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              TCK_O,
    output logic              TMS_O,
    output logic              TDI_O,
    input  logic              TDO_I,
    output logic              busy,
    output logic [3:0]        tap_state
);

    localparam int STEP_W = LEN_W + 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    ctrl_state_t       state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [DIV_W-1:0]  div_cnt;
    cmd_op_t           op_q;
    logic [STEP_W-1:0] len_q;      // effective length, 1..DATA_W
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] cap_q;
    logic [STEP_W-1:0] len_eff;
    logic [STEP_W-1:0] pre_last;
    logic              running, phase_end, tck_rise, tck_fall, accept;

    // TMS value for the tick that starts in controller state st at step stp
    function automatic logic tick_tms(input ctrl_state_t st, input logic [STEP_W-1:0] stp,
                                      input cmd_op_t op, input logic [STEP_W-1:0] n);
        logic t;
        t = 1'b0;
        case (st)
            ST_INIT: t = (stp < STEP_W'(INIT_TICKS - 1));
            ST_PRE: begin
                case (op)
                    OP_RESET: t = (stp < STEP_W'(RESET_TICKS - 1));
                    OP_IR:    t = (stp < STEP_W'(IR_PRE_ONES));
                    OP_DR:    t = (stp == '0);
                    default:  t = 1'b0;
                endcase
            end
            ST_SHIFT: t = (stp == n - STEP_W'(1));   // leave Shift on the last bit
            ST_POST:  t = (stp == '0);               // Exit1 -> Update, then back to RTI
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    // TDI value for the tick that starts in controller state st at step stp
    function automatic logic tick_tdi(input ctrl_state_t st, input logic [STEP_W-1:0] stp,
                                      input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] shifted;
        shifted = data >> stp;
        return (st == ST_SHIFT) && shifted[0];
    endfunction

    assign running   = state inside {ST_INIT, ST_PRE, ST_SHIFT, ST_POST};
    assign phase_end = running && (div_cnt == DIV_LAST);
    assign tck_rise  = phase_end && !TCK_O;
    assign tck_fall  = phase_end && TCK_O;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_data  = cap_q;

    // Normalise the requested length and pick the last preamble step
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        len_eff = STEP_W'(cmd_len);
        if (cmd_len == '0) begin
            len_eff = STEP_W'(1);
        end else if (STEP_W'(cmd_len) > STEP_W'(DATA_W)) begin
            len_eff = STEP_W'(DATA_W);
        end
        pre_last = STEP_W'(DR_PRE_TICKS - 1);
        case (op_q)
            OP_RESET: pre_last = STEP_W'(RESET_TICKS - 1);
            OP_IR:    pre_last = STEP_W'(IR_PRE_TICKS - 1);
            OP_DR:    pre_last = STEP_W'(DR_PRE_TICKS - 1);
            OP_IDLE:  pre_last = len_q - STEP_W'(1);
            default:  pre_last = STEP_W'(DR_PRE_TICKS - 1);
        endcase
    end

    // Controller next state: phases advance only at the end of a tick
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            ST_INIT: begin
                if (tck_fall) begin
                    if (step == STEP_W'(INIT_TICKS - 1)) begin
                        state_nxt = ST_IDLE;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_PRE;
                    step_nxt  = '0;
                end
            end
            ST_PRE: begin
                if (tck_fall) begin
                    if (step == pre_last) begin
                        state_nxt = (op_q == OP_IR || op_q == OP_DR) ? ST_SHIFT : ST_DONE;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (tck_fall) begin
                    if (step == len_q - STEP_W'(1)) begin
                        state_nxt = ST_POST;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            ST_POST: begin
                if (tck_fall) begin
                    if (step == STEP_W'(POST_TICKS - 1)) begin
                        state_nxt = ST_DONE;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Controller state and step counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Latch the command on accept with its length already normalised
    // NOTE: payload registers carry no reset; they are always written on accept before use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q   <= cmd_op_t'(cmd_op);
            len_q  <= len_eff;
            data_q <= cmd_data;
        end
    end

    // Tick generator: CLK_DIV cycles low, CLK_DIV cycles high, parked low when idle
    always_ff @(posedge CLK) begin
        if (RST || !running) begin
            div_cnt <= '0;
            TCK_O   <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            TCK_O   <= !TCK_O;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // TMS/TDI are set up at the start of each tick's low phase
    always_ff @(posedge CLK) begin
        if (RST) begin
            TMS_O <= 1'b1;
            TDI_O <= 1'b0;
        end else if (accept) begin
            TMS_O <= tick_tms(ST_PRE, '0, cmd_op_t'(cmd_op), len_eff);
            TDI_O <= 1'b0;
        end else if (tck_fall) begin
            TMS_O <= tick_tms(state_nxt, step_nxt, op_q, len_q);
            TDI_O <= tick_tdi(state_nxt, step_nxt, data_q);
        end
    end

    // Capture TDO on shift-tick rises; pulse rsp_valid as the controller returns to IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_q     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= (state == ST_DONE);
            if (accept) begin
                cap_q <= '0;
            end else if (tck_rise && state == ST_SHIFT) begin
                cap_q <= cap_q | (DATA_W'(TDO_I) << step);
            end
        end
    end

    jtag_tap_mirror u_tap_mirror (
        .CLK       (CLK),
        .RST       (RST),
        .tck_rise  (tck_rise),
        .tms       (TMS_O),
        .tap_state (tap_state)
    );

endmodule
